// File: rtl/logic_gates_tester_pkg.sv
// Shared encodings for the gate tester: FSM states, vector count, gate bit positions.
// Pure declarations; no logic, no latency, no flow control.
package logic_gates_tester_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int NUM_VEC   = 4;
    localparam int NUM_GATES = 3;

    localparam int GATE_AND = 0;
    localparam int GATE_OR  = 1;
    localparam int GATE_NOT = 2;

endpackage

// File: rtl/logic_gates_tester_if.sv
// Bundle of tester control, operand and gate-result signals with tester/environment views.
// Wires only; no latency, no flow control beyond the start/busy/done pulse protocol.
interface logic_gates_tester_if;
    logic       start;
    logic       a;
    logic       b;
    logic       gate_and;
    logic       gate_or;
    logic       gate_not;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_cnt;
    logic [3:0] err_mask;
    logic [2:0] fail_gate;

    modport master (
        input  start, gate_and, gate_or, gate_not,
        output a, b, busy, done, pass, err_cnt, err_mask, fail_gate
    );

    modport slave (
        output start, gate_and, gate_or, gate_not,
        input  a, b, busy, done, pass, err_cnt, err_mask, fail_gate
    );
endinterface

// File: rtl/logic_gates_expect.sv
// Reference gate values {NOT,OR,AND} for operands (A,B).
// Purely combinational, zero latency, no backpressure.
module logic_gates_expect
    import logic_gates_tester_pkg::*;
(
    input  logic                 a,
    input  logic                 b,
    output logic [NUM_GATES-1:0] gates
);

    always_comb begin
        gates           = '0;
        gates[GATE_AND] = a & b;
        gates[GATE_OR]  = a | b;
        gates[GATE_NOT] = ~a;
    end

endmodule

// File: rtl/logic_gates_tester.sv
// Walks operand vectors 00..11 through an external gate block and grades the returned AND/OR/NOT.
// Run length 4*SETTLE+1 cycles from start to done pulse; start is ignored while busy or done.
module logic_gates_tester
    import logic_gates_tester_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iStart,
    input  logic       iAnd,
    input  logic       iOr,
    input  logic       iNot,
    output logic       oA,
    output logic       oB,
    output logic       oBusy,
    output logic       oDone,
    output logic       oPass,
    output logic [2:0] oErrCnt,
    output logic [3:0] oErrMask,
    output logic [2:0] oFailGate
);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [1:0]            vec_q, vec_d;
    logic                  a_q, a_d;
    logic                  b_q, b_d;
    logic                  pass_q, pass_d;
    logic [2:0]            err_cnt_q, err_cnt_d;
    logic [3:0]            err_mask_q, err_mask_d;
    logic [NUM_GATES-1:0]  fail_gate_q, fail_gate_d;
    logic [NUM_GATES-1:0]  exp_gates, obs_gates, mism;

    // Expected values follow the registered operands, i.e. the vector currently on the pins.
    logic_gates_expect u_expect (
        .a     (a_q),
        .b     (b_q),
        .gates (exp_gates)
    );

    always_comb begin
        obs_gates           = '0;
        obs_gates[GATE_AND] = iAnd;
        obs_gates[GATE_OR]  = iOr;
        obs_gates[GATE_NOT] = iNot;
        mism                = obs_gates ^ exp_gates;

        state_d     = state_q;
        cnt_d       = cnt_q;
        vec_d       = vec_q;
        pass_d      = pass_q;
        err_cnt_d   = err_cnt_q;
        err_mask_d  = err_mask_q;
        fail_gate_d = fail_gate_q;

        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    state_d     = ST_DRIVE;
                    cnt_d       = '0;
                    vec_d       = '0;
                    pass_d      = 1'b0;
                    err_cnt_d   = '0;
                    err_mask_d  = '0;
                    fail_gate_d = '0;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == 4'(SETTLE - 1)) begin
                    cnt_d = '0;
                    if (|mism) begin
                        err_mask_d[vec_q] = 1'b1;
                        err_cnt_d         = err_cnt_q + 3'd1;
                        fail_gate_d       = fail_gate_q | mism;
                    end
                    if (vec_q == 2'(NUM_VEC - 1)) begin
                        // Pass is latched on entry to DONE so it is valid alongside the done pulse.
                        state_d = ST_DONE;
                        vec_d   = '0;
                        pass_d  = (err_cnt_d == 3'd0);
                    end else begin
                        vec_d = vec_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        a_d = (state_d == ST_DRIVE) && vec_d[1];
        b_d = (state_d == ST_DRIVE) && vec_d[0];
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            vec_q       <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            err_mask_q  <= '0;
            fail_gate_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vec_q       <= vec_d;
            a_q         <= a_d;
            b_q         <= b_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            err_mask_q  <= err_mask_d;
            fail_gate_q <= fail_gate_d;
        end
    end

    assign oA        = a_q;
    assign oB        = b_q;
    assign oBusy     = (state_q == ST_DRIVE);
    assign oDone     = (state_q == ST_DONE);
    assign oPass     = pass_q;
    assign oErrCnt   = err_cnt_q;
    assign oErrMask  = err_mask_q;
    assign oFailGate = fail_gate_q;

endmodule

// File: tb/tb_logic_gates_tester.sv
// Bench for logic_gates_tester: SETTLE=2 and SETTLE=1 instances against a configurable gate model.
// Scoreboard queues hold expected operand sequence and run results.
module tb_logic_gates_tester;

    typedef struct packed {
        logic       pass;
        logic [2:0] cnt;
        logic [3:0] mask;
        logic [2:0] fail;
    } res_t;

    logic       clk;
    logic       rst;
    logic [1:0] mode;
    int         checks;
    int         errors;
    res_t       exp_q[$];
    logic [1:0] ab_q[$];

    logic_gates_tester_if gif2 ();
    logic_gates_tester_if gif1 ();

    // Gate block model: 0 = correct, 1 = AND stuck at 0, 2 = NOT wired as buffer of A.
    assign gif2.gate_and = (mode == 2'd1) ? 1'b0 : (gif2.a & gif2.b);
    assign gif2.gate_or  = gif2.a | gif2.b;
    assign gif2.gate_not = (mode == 2'd2) ? gif2.a : ~gif2.a;
    assign gif1.gate_and = (mode == 2'd1) ? 1'b0 : (gif1.a & gif1.b);
    assign gif1.gate_or  = gif1.a | gif1.b;
    assign gif1.gate_not = (mode == 2'd2) ? gif1.a : ~gif1.a;

    logic_gates_tester #(.SETTLE(2)) dut2 (
        .iClk(clk), .iRst(rst), .iStart(gif2.start),
        .iAnd(gif2.gate_and), .iOr(gif2.gate_or), .iNot(gif2.gate_not),
        .oA(gif2.a), .oB(gif2.b), .oBusy(gif2.busy), .oDone(gif2.done),
        .oPass(gif2.pass), .oErrCnt(gif2.err_cnt), .oErrMask(gif2.err_mask),
        .oFailGate(gif2.fail_gate)
    );

    logic_gates_tester #(.SETTLE(1)) dut1 (
        .iClk(clk), .iRst(rst), .iStart(gif1.start),
        .iAnd(gif1.gate_and), .iOr(gif1.gate_or), .iNot(gif1.gate_not),
        .oA(gif1.a), .oB(gif1.b), .oBusy(gif1.busy), .oDone(gif1.done),
        .oPass(gif1.pass), .oErrCnt(gif1.err_cnt), .oErrMask(gif1.err_mask),
        .oFailGate(gif1.fail_gate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [1:0] m);
        res_t       r;
        logic [1:0] v;
        logic       a, b, o_and, o_or, o_not;
        logic [2:0] mm;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            v     = 2'(i);
            a     = v[1];
            b     = v[0];
            o_and = (m == 2'd1) ? 1'b0 : (a & b);
            o_or  = a | b;
            o_not = (m == 2'd2) ? a : ~a;
            mm    = {o_not ^ ~a, o_or ^ (a | b), o_and ^ (a & b)};
            if (mm != 3'b000) begin
                r.mask[i] = 1'b1;
                r.cnt     = r.cnt + 3'd1;
                r.fail    = r.fail | mm;
            end
        end
        r.pass = (r.cnt == 3'd0);
        return r;
    endfunction

    task automatic push_run(input logic [1:0] m, input bit with_result);
        if (with_result) exp_q.push_back(model(m));
        for (int v = 0; v < 4; v++) begin
            ab_q.push_back(2'(v));
            ab_q.push_back(2'(v));
        end
    endtask

    task automatic wait_done(input bit sel1, input int exp_n, input bit drop, input string tag);
        int n;
        bit d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (drop && n == 1) begin
                if (sel1) gif1.start = 1'b0;
                else      gif2.start = 1'b0;
            end
            d = sel1 ? gif1.done : gif2.done;
        end while (!d && n < 60);
        check({tag, "_latency"}, 8'(n), 8'(exp_n));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_a"},     8'(gif2.a),         8'd0);
        check({tag, "_b"},     8'(gif2.b),         8'd0);
        check({tag, "_busy"},  8'(gif2.busy),      8'd0);
        check({tag, "_done"},  8'(gif2.done),      8'd0);
        check({tag, "_pass"},  8'(gif2.pass),      8'd0);
        check({tag, "_cnt"},   8'(gif2.err_cnt),   8'd0);
        check({tag, "_mask"},  8'(gif2.err_mask),  8'd0);
        check({tag, "_fail"},  8'(gif2.fail_gate), 8'd0);
    endtask

    // Scoreboard: operand pairs popped while busy, run results popped on the done pulse.
    always @(negedge clk) begin
        if (gif2.busy === 1'b1) begin
            if (ab_q.size() > 0) check("ab_seq", 8'({gif2.a, gif2.b}), 8'(ab_q.pop_front()));
            else                 check("busy_unexpected", 8'(gif2.busy), 8'd0);
        end
        if (gif2.done === 1'b1) begin
            if (exp_q.size() > 0) begin
                res_t e;
                e = exp_q.pop_front();
                check("res_pass", 8'(gif2.pass),      8'(e.pass));
                check("res_cnt",  8'(gif2.err_cnt),   8'(e.cnt));
                check("res_mask", 8'(gif2.err_mask),  8'(e.mask));
                check("res_fail", 8'(gif2.fail_gate), 8'(e.fail));
                check("res_busy", 8'(gif2.busy),      8'd0);
            end else begin
                check("done_unexpected", 8'(gif2.done), 8'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        mode       = 2'd0;
        rst        = 1'b1;
        gif2.start = 1'b0;
        gif1.start = 1'b0;
        repeat (3) @(negedge clk);
        check_cleared("reset");

        // Reset wins over a simultaneous start.
        gif2.start = 1'b1;
        @(negedge clk);
        check("rst_prio_busy", 8'(gif2.busy), 8'd0);
        gif2.start = 1'b0;
        rst        = 1'b0;
        @(negedge clk);

        // Correct gates, then AND stuck at 0, then NOT as buffer.
        for (int m = 0; m < 3; m++) begin
            mode = 2'(m);
            push_run(2'(m), 1'b1);
            gif2.start = 1'b1;
            wait_done(1'b0, 9, 1'b1, "run");
            @(negedge clk);
            check("hold_pass", 8'(gif2.pass),     8'(model(2'(m)).pass));
            check("hold_cnt",  8'(gif2.err_cnt),  8'(model(2'(m)).cnt));
            check("idle_busy", 8'(gif2.busy),     8'd0);
        end

        // Reset while vector 2 is on the pins: abort, no done, results gone.
        mode = 2'd0;
        push_run(2'd0, 1'b0);
        gif2.start = 1'b1;
        @(negedge clk);
        gif2.start = 1'b0;
        repeat (4) @(negedge clk);
        check("midrun_vec2", 8'({gif2.a, gif2.b}), 8'd2);
        rst = 1'b1;
        @(negedge clk);
        check_cleared("midrun_rst");
        rst = 1'b0;
        ab_q.delete();
        repeat (12) @(negedge clk);
        check("midrun_no_done", 8'(gif2.done), 8'd0);

        // Start held high: no restart until IDLE, second run clears old failures.
        mode = 2'd1;
        push_run(2'd1, 1'b1);
        push_run(2'd0, 1'b1);
        gif2.start = 1'b1;
        wait_done(1'b0, 9, 1'b0, "held1");
        mode = 2'd0;
        @(negedge clk);
        check("held_idle_busy", 8'(gif2.busy),    8'd0);
        check("held_idle_cnt",  8'(gif2.err_cnt), 8'd1);
        @(negedge clk);
        check("held_rerun_busy", 8'(gif2.busy),      8'd1);
        check("held_clr_cnt",    8'(gif2.err_cnt),   8'd0);
        check("held_clr_mask",   8'(gif2.err_mask),  8'd0);
        check("held_clr_fail",   8'(gif2.fail_gate), 8'd0);
        check("held_clr_pass",   8'(gif2.pass),      8'd0);
        gif2.start = 1'b0;
        wait_done(1'b0, 8, 1'b0, "held2");
        repeat (2) @(negedge clk);

        // SETTLE=1 instance with correct gates.
        mode       = 2'd0;
        gif1.start = 1'b1;
        wait_done(1'b1, 5, 1'b1, "settle1");
        check("settle1_pass", 8'(gif1.pass),    8'd1);
        check("settle1_cnt",  8'(gif1.err_cnt), 8'd0);
        repeat (2) @(negedge clk);

        check("sb_res_left", 8'(exp_q.size()), 8'd0);
        check("sb_ab_left",  8'(ab_q.size()),  8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
